// File: rtl/rs_frame_buffer_if.sv
// Symbol/handshake bundle between the receive front end, the decoder control and rs_frame_buffer.
// The producer/controller side takes the master modport and the buffer takes the slave modport.
interface rs_frame_buffer_if #(
  parameter int M = 8
) ();
  logic [M-1:0] data_in;
  logic         data_in_valid;
  logic         frame_start;
  logic         replay_start;
  logic [M-1:0] data_shifted;
  logic         shifted_valid;
  logic [1:0]   bank_full;

  modport master (
    output data_in, data_in_valid, frame_start, replay_start,
    input  data_shifted, shifted_valid, bank_full
  );

  modport slave (
    input  data_in, data_in_valid, frame_start, replay_start,
    output data_shifted, shifted_valid, bank_full
  );
endinterface

// File: rtl/rs_frame_buffer.sv
// Two-bank ping-pong RS frame buffer: captures frame k+1 while frame k is replayed symbol by symbol.
// Optional sticky overflow/underflow status with err_clr is built when RS_BUF_STATUS_EN is defined.
module rs_frame_buffer #(
  parameter int N = 255,
  parameter int M = 8
) (
  input  logic clk_in,
  input  logic sys_rst,
  rs_frame_buffer_if.slave bus
`ifdef RS_BUF_STATUS_EN
  ,
  input  logic err_clr,
  output logic overflow,
  output logic underflow
`endif
);

  localparam int         AW   = $clog2(2 * N);
  localparam logic [7:0] LAST = 8'(N - 1);

  localparam logic [0:0] W_IDLE = 1'b0;
  localparam logic [0:0] W_FILL = 1'b1;
  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_PLAY = 1'b1;

  logic [0:0]   wr_state;
  logic [0:0]   rd_state;
  logic [7:0]   wr_cnt;
  logic [7:0]   rd_cnt;
  logic         wr_bank;
  logic         rd_bank;
  logic [1:0]   full_q;
  logic [M-1:0] mem [2*N];
  logic [M-1:0] rd_q;

  // Writer decode
  logic          wr_start;
  logic          wr_en;
  logic          wr_done;
  logic [7:0]    wr_idx;
  logic [AW-1:0] wr_addr;

  // Reader decode
  logic          rd_go;
  logic          rd_end;
  logic          rd_en;
  logic [8:0]    rd_idx;
  logic [AW-1:0] rd_addr;

  logic [1:0]    full_set;
  logic [1:0]    full_clr;

  always_comb begin
    wr_start = bus.data_in_valid && bus.frame_start && !full_q[wr_bank];
    // A frame_start inside FILL restarts the same (never full) bank at address 0.
    wr_en    = wr_start ||
               (bus.data_in_valid && !bus.frame_start && (wr_state == W_FILL));
    wr_idx   = bus.frame_start ? 8'd0 : wr_cnt;
    wr_done  = wr_en && (wr_idx == LAST);
    wr_addr  = wr_bank ? (AW'(N) + AW'(wr_idx)) : AW'(wr_idx);
  end

  always_comb begin
    rd_go   = bus.replay_start && (rd_state == R_IDLE) && full_q[rd_bank];
    rd_end  = (rd_state == R_PLAY) && (rd_cnt == LAST);
    rd_en   = rd_go || (rd_state == R_PLAY);
    // Address runs one symbol ahead of the one on data_shifted to hide the RAM read latency.
    rd_idx  = (rd_state == R_PLAY) ? ({1'b0, rd_cnt} + 9'd1) : 9'd0;
    rd_addr = rd_bank ? (AW'(N) + AW'(rd_idx)) : AW'(rd_idx);
  end

  always_comb begin
    full_set = {wr_done && wr_bank, wr_done && !wr_bank};
    full_clr = {rd_end && rd_bank, rd_end && !rd_bank};
  end

  // NOTE: sequential state uses non-blocking assignments and clears asynchronously on sys_rst.
  always_ff @(posedge clk_in or posedge sys_rst) begin
    if (sys_rst) begin
      wr_state <= W_IDLE;
      wr_cnt   <= 8'd0;
      wr_bank  <= 1'b0;
    end else if (wr_en) begin
      if (wr_done) begin
        wr_state <= W_IDLE;
        wr_cnt   <= 8'd0;
        wr_bank  <= ~wr_bank;
      end else begin
        wr_state <= W_FILL;
        wr_cnt   <= wr_idx + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_in or posedge sys_rst) begin
    if (sys_rst) begin
      rd_state <= R_IDLE;
      rd_cnt   <= 8'd0;
      rd_bank  <= 1'b0;
    end else if (rd_go) begin
      rd_state <= R_PLAY;
      rd_cnt   <= 8'd0;
    end else if (rd_end) begin
      rd_state <= R_IDLE;
      rd_cnt   <= 8'd0;
      rd_bank  <= ~rd_bank;
    end else if (rd_state == R_PLAY) begin
      rd_cnt   <= rd_cnt + 8'd1;
    end
  end

  // Writer completion and reader release always hit different banks, so both apply.
  always_ff @(posedge clk_in or posedge sys_rst) begin
    if (sys_rst) begin
      full_q <= 2'b00;
    end else begin
      full_q <= (full_q & ~full_clr) | full_set;
    end
  end

  // NOTE: the symbol store has no reset so it maps onto block RAM; its contents are don't-care after reset.
  always_ff @(posedge clk_in) begin
    if (wr_en) begin
      mem[wr_addr] <= bus.data_in;
    end
    if (rd_en) begin
      rd_q <= mem[rd_addr];
    end
  end

  assign bus.shifted_valid = (rd_state == R_PLAY);
  assign bus.data_shifted  = (rd_state == R_PLAY) ? rd_q : '0;
  assign bus.bank_full     = full_q;

`ifdef RS_BUF_STATUS_EN
  logic ovf_evt;
  logic unf_evt;

  always_comb begin
    ovf_evt = bus.data_in_valid && bus.frame_start && full_q[wr_bank];
    unf_evt = bus.replay_start && (rd_state == R_IDLE) && !full_q[rd_bank];
  end

  // A coincident event wins over err_clr.
  always_ff @(posedge clk_in or posedge sys_rst) begin
    if (sys_rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= ovf_evt | (overflow  & ~err_clr);
      underflow <= unf_evt | (underflow & ~err_clr);
    end
  end
`endif

  a_play_holds_full: assert property (
    @(posedge clk_in) disable iff (sys_rst) (rd_state == R_PLAY) |-> full_q[rd_bank]
  );

  a_fill_not_full: assert property (
    @(posedge clk_in) disable iff (sys_rst) (wr_state == W_FILL) |-> !full_q[wr_bank]
  );

endmodule

// File: tb/tb_rs_frame_buffer.sv
// Scoreboard bench for rs_frame_buffer: a frame-level FIFO model predicts replayed symbols and occupancy.
// Directed scenarios are followed by a randomized phase with gaps, restarts and stray replay pulses.
module tb_rs_frame_buffer;
  localparam int N = 255;
  localparam int M = 8;

  logic clk_in = 1'b0;
  logic sys_rst = 1'b1;
  bit   clr_drv = 1'b0;

  always #5 clk_in = ~clk_in;

  rs_frame_buffer_if #(.M(M)) bus ();

`ifdef RS_BUF_STATUS_EN
  logic err_clr;
  logic overflow;
  logic underflow;
  assign err_clr = clr_drv;
`endif

  rs_frame_buffer #(.N(N), .M(M)) dut (
    .clk_in   (clk_in),
    .sys_rst  (sys_rst),
    .bus      (bus)
`ifdef RS_BUF_STATUS_EN
    ,
    .err_clr  (err_clr),
    .overflow (overflow),
    .underflow(underflow)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model: complete frames waiting (concatenated, oldest first), frame being collected,
  // remaining replay cycles, and the expected replay stream.
  logic [7:0] frames[$];
  logic [7:0] part[$];
  bit         in_frame = 1'b0;
  int         play_rem = 0;
  logic [7:0] exp_q[$];
  bit         ovf_m = 1'b0;
  bit         unf_m = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int occupancy();
    return frames.size() / N + ((play_rem > 0) ? 1 : 0);
  endfunction

  function automatic bit rnd_pulse(input int pct);
    return $urandom_range(0, 99) < pct;
  endfunction

  task automatic model_reset();
    frames.delete();
    part.delete();
    exp_q.delete();
    in_frame = 1'b0;
    play_rem = 0;
    ovf_m    = 1'b0;
    unf_m    = 1'b0;
  endtask

  task automatic model_step(input bit v, input bit fs, input logic [7:0] d, input bit rs, input bit clr);
    int occ;
    int ready;
    bit ovf_e;
    bit unf_e;
    occ   = occupancy();
    ready = frames.size() / N;
    ovf_e = 1'b0;
    unf_e = 1'b0;
    if (play_rem > 0) begin
      play_rem--;
    end else if (rs) begin
      if (ready == 0) begin
        unf_e = 1'b1;
      end else begin
        for (int i = 0; i < N; i++) exp_q.push_back(frames.pop_front());
        play_rem = N;
      end
    end
    if (v) begin
      if (fs) begin
        part.delete();
        if (occ == 2) begin
          ovf_e    = 1'b1;
          in_frame = 1'b0;
        end else begin
          part.push_back(d);
          in_frame = 1'b1;
        end
      end else if (in_frame) begin
        part.push_back(d);
      end
      if (in_frame && part.size() == N) begin
        for (int i = 0; i < N; i++) frames.push_back(part[i]);
        part.delete();
        in_frame = 1'b0;
      end
    end
    ovf_m = ovf_e ? 1'b1 : (clr ? 1'b0 : ovf_m);
    unf_m = unf_e ? 1'b1 : (clr ? 1'b0 : unf_m);
  endtask

  task automatic cycle(input bit v, input bit fs, input logic [7:0] d, input bit rs);
    bus.data_in_valid = v;
    bus.frame_start   = fs;
    bus.data_in       = d;
    bus.replay_start  = rs;
    @(posedge clk_in);
    model_step(v, fs, d, rs, clr_drv);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 8'($urandom), 1'b0);
  endtask

  // mode 0: ramp j, mode 1: constant val, mode 2: random symbols
  task automatic send_frame(input int mode, input logic [7:0] val, input int len,
                            input int gap_pct, input int rs_pct);
    for (int j = 0; j < len; j++) begin
      logic [7:0] d;
      while ($urandom_range(0, 99) < gap_pct) cycle(1'b0, 1'b0, 8'($urandom), rnd_pulse(rs_pct));
      d = (mode == 0) ? 8'(j) : (mode == 1) ? val : 8'($urandom);
      cycle(1'b1, j == 0, d, rnd_pulse(rs_pct));
    end
  endtask

  task automatic replay();
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
  endtask

  task automatic wait_done();
    int guard;
    guard = 0;
    while (play_rem > 0 && guard < 2000) begin
      idle(1);
      guard++;
    end
    check("replay_finished", bus.shifted_valid, 1'b0);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a replayed symbol.
  always @(negedge clk_in) begin
    if (!sys_rst) begin
      check("shifted_valid", bus.shifted_valid, play_rem > 0);
      if (bus.shifted_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_symbol actual=%0h expected=none at %0t", bus.data_shifted, $time);
        end else begin
          check("data_shifted", bus.data_shifted, exp_q.pop_front());
        end
      end else begin
        check("data_idle_zero", bus.data_shifted, 8'h00);
      end
      check("bank_occupancy", $countones(bus.bank_full), occupancy());
`ifdef RS_BUF_STATUS_EN
      check("overflow", overflow, ovf_m);
      check("underflow", underflow, unf_m);
`endif
    end
  end

  initial begin
    bus.data_in       = '0;
    bus.data_in_valid = 1'b0;
    bus.frame_start   = 1'b0;
    bus.replay_start  = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    check("rst_valid", bus.shifted_valid, 1'b0);
    check("rst_data", bus.data_shifted, 8'h00);
    check("rst_bank_full", bus.bank_full, 2'b00);
`ifdef RS_BUF_STATUS_EN
    check("rst_overflow", overflow, 1'b0);
    check("rst_underflow", underflow, 1'b0);
`endif
    sys_rst = 1'b0;
    idle(2);

    // Ramp frame, replay
    send_frame(0, 8'h00, N, 0, 0);
    check("t1_bank_full", bus.bank_full, 2'b01);
    replay();
    wait_done();
    check("t1_bank_free", bus.bank_full, 2'b00);

    // Back-to-back A then B, then a third frame that must be dropped
    send_frame(1, 8'hA5, N, 0, 0);
    send_frame(1, 8'h3C, N, 0, 0);
    check("t2_both_full", bus.bank_full, 2'b11);
    send_frame(1, 8'h77, N, 10, 0);
    check("t3_still_full", bus.bank_full, 2'b11);
`ifdef RS_BUF_STATUS_EN
    check("t3_overflow_set", overflow, 1'b1);
    clr_drv = 1'b1;
    idle(1);
    clr_drv = 1'b0;
    check("t3_overflow_clr", overflow, 1'b0);
`endif
    replay();
    wait_done();
    check("t2_after_a", bus.bank_full, 2'b01);
    replay();
    wait_done();
    check("t2_after_b", bus.bank_full, 2'b00);

    // Restart at symbol 100, then a clean 0x11 frame
    send_frame(2, 8'h00, 100, 0, 0);
    send_frame(1, 8'h11, N, 0, 0);
    replay();
    wait_done();

    // Underflow, then a second replay_start in the middle of PLAY
    replay();
    check("t5_no_play", bus.shifted_valid, 1'b0);
`ifdef RS_BUF_STATUS_EN
    check("t5_underflow", underflow, 1'b1);
`endif
    send_frame(2, 8'h00, N, 15, 0);
    replay();
    idle(20);
    replay();
    wait_done();

    // Reset during replay symbol 50
    send_frame(0, 8'h00, N, 0, 0);
    replay();
    idle(50);
    sys_rst = 1'b1;
    model_reset();
    #1;
    check("t6_rst_valid", bus.shifted_valid, 1'b0);
    check("t6_rst_data", bus.data_shifted, 8'h00);
    check("t6_rst_bank_full", bus.bank_full, 2'b00);
    @(posedge clk_in);
    #1;
    sys_rst = 1'b0;
    idle(2);
    send_frame(2, 8'h00, N, 5, 0);
    replay();
    wait_done();

    // Randomized traffic: gaps, truncated frames, stray replay pulses, random status clears
    for (int k = 0; k < 14; k++) begin
      int len;
      len = ($urandom_range(0, 4) == 0) ? $urandom_range(1, N - 1) : N;
      clr_drv = $urandom_range(0, 3) == 0;
      send_frame(2, 8'h00, len, 20, 2);
      clr_drv = 1'b0;
      for (int g = $urandom_range(0, 40); g > 0; g--) cycle(1'b0, 1'b0, 8'($urandom), rnd_pulse(5));
    end

    // Drain whatever complete frames remain
    for (int k = 0; k < 3; k++) begin
      wait_done();
      if (frames.size() >= N) replay();
    end
    wait_done();
    check("scoreboard_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
